divider_iterative: RTL and testbench
====================================

// Module: divider_iterative
// PURPOSE
//  Iterative radix-2 restoring divider; inverse companion of the iterative multiplier in the functional-unit set.
//  Accepts a dividend/divisor pair on a valid_in pulse and produces quotient and remainder after a fixed latency.
//  Backs MIPS DIV/DIVU (HI/LO) in the CPU datapath; signedness is selected per operation.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits (>=4)
// PORTS
//  clk        in   1      rising-edge clock; single clock domain
//  reset      in   1      synchronous, active-high reset
//  valid_in   in   1      start pulse; a, b and is_signed sampled on the same edge
//  is_signed  in   1      1 = two's-complement divide (DIV), 0 = unsigned divide (DIVU)
//  a          in   WIDTH  dividend
//  b          in   WIDTH  divisor
//  busy       out  1      high while an operation is in flight (RUN or FIX)
//  valid_out  out  1      one-cycle pulse; q and r are valid from this cycle on
//  q          out  WIDTH  quotient (LO); held until the next completion
//  r          out  WIDTH  remainder (HI); held until the next completion
// BEHAVIOUR
//  Reset (sync, high) forces: state=IDLE, busy=0, valid_out=0, q=0, r=0, iteration count=0. This applies in any state, so reset mid-operation discards the in-flight divide.
//  States and transitions:
//    IDLE  -> RUN  on valid_in.
//    RUN   -> FIX  after WIDTH iterations.
//    FIX   -> IDLE unconditionally.
//  Capture edge (valid_in=1), in any state:
//    - Latch |a|, |b| (magnitudes when is_signed, raw values otherwise), neg_q = sa^sb, neg_r = sa (signed only), div0 = (b==0).
//    - Clear the partial remainder and iteration count; go to RUN.
//  Restart: valid_in during RUN or FIX aborts the current operation and restarts with the new operands.
//    - No valid_out is produced for the aborted operation.
//    - q and r keep their previous values.
//  RUN, one iteration per cycle:
//    - {rem, dvd} <<= 1.
//    - trial = rem - dvs, computed WIDTH+1 bits wide.
//    - If no borrow: rem = trial and the quotient bit is 1; otherwise rem is restored and the quotient bit is 0.
//    - count increments.
//  FIX edge:
//    - q <= neg_q ? -quo : quo; r <= neg_r ? -rem : rem; valid_out <= 1.
//    - If div0: q <= all-ones, r <= a (original dividend); sign correction is not applied.
//  Overflow: signed MIN_INT / -1 gives q=MIN_INT, r=0 through the magnitude path with no special case.
//  Latency: valid_in sampled at edge E0; valid_out is high in the cycle after edge E(WIDTH+1), which is 34 cycles for WIDTH=32.
//    - Latency is fixed, including div0 and a==0; there is no early termination.
//  valid_out: exactly one cycle, deasserts on the next edge. busy = (state != IDLE).
//  Back-to-back: valid_in may be asserted in the same cycle that valid_out is high; the result registers still hold the finished result.
//  All arithmetic is modulo 2^WIDTH. Sign rules: quotient truncates toward zero; the remainder takes the dividend's sign.
// STRUCTURE
//  Shared package div_pkg: typedef enum {DIV_IDLE, DIV_RUN, DIV_FIX} div_state_t; localparam DIV_WIDTH_DEFAULT = 32.
//  Sub-module div_step (combinational): takes (rem, dvd_msb, dvs) and returns (rem_next, q_bit).
//    - Keeps the restoring-step borrow logic separately testable.
//  Top level holds the FSM, the counter ($clog2(WIDTH)+1 bits), the operand/remainder/quotient registers and the output registers.
// TESTING
//  1. Unsigned 100/7 -> q=14, r=2; valid_out exactly 34 cycles after valid_in and one cycle wide; busy high throughout.
//  2. Signed -100/7 -> q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2); signed 100/-7 -> q=-14, r=2.
//  3. Divide-by-zero: 5/0 (either signedness) -> q=0xFFFFFFFF, r=5, same 34-cycle latency.
//  4. Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0; unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//  5. Restart: start 1000/3, re-pulse valid_in with 81/9 at cycle 10.
//     -> Exactly one valid_out, 34 cycles after the second pulse, with q=9, r=0.
//  6. Reset at cycle 15 of 1000/3 -> busy=0, valid_out=0, q=r=0 next cycle; no later valid_out; 10/3 afterwards gives q=3, r=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative divider functional unit.
// Imported by the divider top level and its restoring-step datapath.
package div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_RUN,
      DIV_FIX
   } div_state_t;

endpackage

// File: rtl/divider_iterative_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference on no-borrow, otherwise restore.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             borrow;

   assign shifted = {rem, dvd_msb};

   // The borrow comes from the full WIDTH+1-bit compare; whenever there is no
   // borrow the true difference is below 2^WIDTH, so the low bits are exact.
   assign borrow   = (shifted < {1'b0, dvs});
   assign trial    = shifted[WIDTH-1:0] - dvs;
   assign q_bit    = ~borrow;
   assign rem_next = borrow ? shifted[WIDTH-1:0] : trial;

endmodule

// File: rtl/divider_iterative.sv
// Iterative radix-2 restoring divider (MIPS DIV/DIVU): WIDTH iterations plus
// one sign-fix cycle; q is LO, r is HI.
module divider_iterative
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             valid_out,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_t       state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem, dvd, dvs, a_raw;
   logic [WIDTH-1:0] rem_next, a_mag, b_mag;
   logic             q_bit, neg_q, neg_r, div0;
   logic             a_neg, b_neg, last_iter;

   assign a_neg     = is_signed & a[WIDTH-1];
   assign b_neg     = is_signed & b[WIDTH-1];
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b : b;
   assign last_iter = (count == CW'(WIDTH - 1));
   assign busy      = (state != DIV_IDLE);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .dvd_msb  (dvd[WIDTH-1]),
      .dvs      (dvs),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= DIV_IDLE;
      else       state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         DIV_IDLE: if (valid_in) state_next = DIV_RUN;
         DIV_RUN: begin
            if (valid_in)       state_next = DIV_RUN;
            else if (last_iter) state_next = DIV_FIX;
         end
         DIV_FIX:  state_next = valid_in ? DIV_RUN : DIV_IDLE;
         default:  state_next = DIV_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         rem       <= '0;
         q         <= '0;
         r         <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (valid_in) begin
            // A new start wins over FIX, so an aborted divide never publishes.
            count <= '0;
            rem   <= '0;
         end else if (state == DIV_RUN) begin
            count <= count + CW'(1);
            rem   <= rem_next;
         end else if (state == DIV_FIX) begin
            valid_out <= 1'b1;
            if (div0) begin
               q <= '1;
               r <= a_raw;
            end else begin
               q <= neg_q ? -dvd : dvd;
               r <= neg_r ? -rem : rem;
            end
         end
      end
   end

   // NOTE: operand registers are not reset; they are always loaded before being consumed.
   always_ff @(posedge clk) begin
      if (valid_in) begin
         dvd   <= a_mag;
         dvs   <= b_mag;
         a_raw <= a;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         div0  <= (b == '0);
      end else if (state == DIV_RUN) begin
         // Quotient bits enter at the bottom as dividend bits leave the top.
         dvd <= {dvd[WIDTH-2:0], q_bit};
      end
   end

endmodule

// File: tb/tb_divider_iterative.sv
// Scoreboard bench for divider_iterative: directed corner cases followed by
// randomized operands, checked against a plain-arithmetic reference model.
module tb_divider_iterative;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, valid_in, is_signed;
   logic [W-1:0] a, b, q, r;
   logic         busy, valid_out;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           start;
      string        name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   prev_vo = 1'b0;

   divider_iterative #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .valid_out (valid_out),
      .q         (q),
      .r         (r)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
   endtask

   // Reference: truncating division; remainder follows the dividend's sign.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic ms, input string nm);
      exp_t   e;
      longint sa, sd;
      e.name  = nm;
      e.start = 0;
      if (mb == '0) begin
         e.q = '1;
         e.r = ma;
      end else if (ms) begin
         sa  = longint'($signed(ma));
         sd  = longint'($signed(mb));
         e.q = W'(sa / sd);
         e.r = W'(sa % sd);
      end else begin
         e.q = ma / mb;
         e.r = ma % mb;
      end
      return e;
   endfunction

   // Caller must be just after a negedge; returns #1 after the capture edge.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        input bit restart, input string nm);
      exp_t e;
      if (restart && sb.size() != 0) void'(sb.pop_back());
      e       = model(ia, ib, is, nm);
      e.start = cyc + 1;
      sb.push_back(e);
      a         = ia;
      b         = ib;
      is_signed = is;
      valid_in  = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      a        = $urandom();
      b        = $urandom();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         timeout("wait_idle");
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_valid_out();
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (valid_out === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         timeout("wait_valid_out");
         sb.delete();
      end
   endtask

   function automatic logic [W-1:0] pick(input bit divisor);
      case ($urandom_range(0, 5))
         0:       return divisor ? '0 : 32'h8000_0000;
         1:       return divisor ? '1 : '0;
         2:       return W'($urandom_range(0, 20));
         3:       return divisor ? 32'd1 : '1;
         default: return $urandom();
      endcase
   endfunction

   always @(negedge clk) begin
      if (reset !== 1'b0) begin
         prev_vo = 1'b0;
      end else begin
         if (prev_vo) check("valid_out_one_cycle", W'(valid_out), '0);
         if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid_out: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               mon_e = sb.pop_front();
               check({mon_e.name, " q"}, q, mon_e.q);
               check({mon_e.name, " r"}, r, mon_e.r);
               check({mon_e.name, " latency"}, W'(cyc - mon_e.start + 1), W'(W + 2));
            end
         end
         prev_vo = (valid_out === 1'b1);
      end
   end

   initial begin
      int nb;
      reset     = 1'b1;
      valid_in  = 1'b0;
      is_signed = 1'b0;
      a         = '0;
      b         = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", W'(busy), '0);
      check("reset valid_out", W'(valid_out), '0);
      check("reset q", q, '0);
      check("reset r", r, '0);
      @(negedge clk);
      reset = 1'b0;

      // Unsigned 100/7 with busy held for the whole operation.
      @(negedge clk);
      issue(32'd100, 32'd7, 1'b0, 1'b0, "u100/7");
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (valid_out === 1'b1) break;
         if (busy === 1'b1) nb++;
      end
      check("busy cycles", W'(nb), W'(W + 1));
      check("busy at valid_out", W'(busy), '0);
      wait_idle();

      issue(-32'sd100, 32'd7, 1'b1, 1'b0, "s-100/7");
      wait_idle();
      issue(32'd100, -32'sd7, 1'b1, 1'b0, "s100/-7");
      wait_idle();
      issue(32'd5, 32'd0, 1'b0, 1'b0, "u5/0");
      wait_idle();
      issue(32'd5, 32'd0, 1'b1, 1'b0, "s5/0");
      wait_idle();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "sMIN/-1");
      wait_idle();
      issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "uMAX/1");
      wait_idle();

      // Restart: the 1000/3 expectation is replaced by 81/9.
      issue(32'd1000, 32'd3, 1'b0, 1'b0, "u1000/3");
      repeat (9) @(posedge clk);
      @(negedge clk);
      issue(32'd81, 32'd9, 1'b0, 1'b1, "restart81/9");
      wait_idle();

      // Reset mid-operation discards the divide and clears the results.
      issue(32'd1000, 32'd3, 1'b0, 1'b0, "u1000/3_reset");
      repeat (14) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      check("midreset busy", W'(busy), '0);
      check("midreset valid_out", W'(valid_out), '0);
      check("midreset q", q, '0);
      check("midreset r", r, '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("post_reset busy", W'(busy), '0);
      issue(32'd10, 32'd3, 1'b0, 1'b0, "u10/3");
      wait_idle();

      // Random operands, sometimes launched in the valid_out cycle.
      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] ra, rb;
         logic         rs;
         ra = pick(1'b0);
         rb = pick(1'b1);
         rs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0 && sb.size() != 0) begin
            wait_valid_out();
            issue(ra, rb, rs, 1'b0, "rand_b2b");
         end else begin
            wait_idle();
            issue(ra, rb, rs, 1'b0, "rand");
         end
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
